range_filter: RTL
=================

RANGE_FILTER -- requirements
Module: range_filter

Interface
REQ-001 Parameter: CYC_PER_CM, default 2915, echo-high clock cycles per centimetre of range (50 MHz clock, round trip); SHALL be >= 1.
REQ-002 Parameter: FAIL_LIM, default 3, consecutive in_fail pulses that raise out_err; SHALL be 1..7.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  one-cycle pulse: in_cycles holds a completed echo-width measurement.
REQ-006 in_cycles  input  17  echo-high width in clock cycles, unsigned.
REQ-007 in_fail  input  1  one-cycle pulse: measurement timed out, no echo result.
REQ-008 out_valid  output  1  one-cycle pulse: out_cm and out_avg_cm updated.
REQ-009 out_cm  output  17  latest range, centimetres, floor(in_cycles / CYC_PER_CM).
REQ-010 out_avg_cm  output  17  4-sample moving average of out_cm, floor.
REQ-011 out_err  output  1  level: consecutive-fail count >= FAIL_LIM.
REQ-012 busy  output  1  level: high while a conversion is in progress (DIV or AVG).
REQ-013 ovr  output  1  one-cycle pulse: in_valid dropped because busy.

Function
REQ-014 FSM states: IDLE, DIV, AVG; busy SHALL be high exactly in DIV and AVG.
REQ-015 IDLE: in_valid sampled high -> latch in_cycles, clear quotient/remainder, go to DIV.
REQ-016 DIV: restoring shift-subtract divide, one quotient bit per cycle MSB first; exactly 17 cycles; then AVG.
REQ-017 AVG: one cycle; out_cm <= quotient, window shift-in, running sum update; then IDLE with out_valid pulsed.
REQ-018 Latency: out_valid SHALL be high for exactly one cycle, 19 rising edges after the edge sampling in_valid; out_cm/out_avg_cm change only in that same cycle.
REQ-019 Remainder discarded (floor); no rounding.
REQ-020 Window: 4 entries of 17 bits, 19-bit running sum; out_avg_cm = sum >> 2.
REQ-021 Window empty after reset or when out_err asserts; first sample accepted into an empty window SHALL load all 4 entries with that value (priming).
REQ-022 Non-empty window: oldest entry leaves, new entry enters, sum = sum - oldest + new.
REQ-023 in_valid while busy -> ignored, ovr pulses one cycle later; the conversion in progress is unaffected.
REQ-024 in_valid and in_fail in the same cycle -> in_fail processed, in_valid ignored, no ovr.
REQ-025 Fail counter: 3-bit, increments on every in_fail in any state, saturates at 7; cleared on each out_valid.
REQ-026 out_err SHALL assert the cycle after the counter reaches FAIL_LIM and deassert together with the next out_valid.
REQ-027 in_fail in DIV/AVG SHALL NOT abort the conversion; if out_err asserts mid-conversion, the completing sample primes the window.

Reset
REQ-028 rst_n low asynchronously: FSM IDLE; out_valid, out_err, busy, ovr = 0; out_cm, out_avg_cm = 0; window empty, sum 0, fail counter 0.
REQ-029 Reset mid-DIV/AVG: conversion discarded, no out_valid after release.
REQ-030 First in_valid SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-031 in_cycles 29150, then 29149 (default params) -> out_cm 10, then 9; out_valid 19 edges after each in_valid; busy high 18 cycles each.
REQ-032 After reset, samples 29150, 58300, 87450, 116600 -> out_avg_cm 10, 12, 17, 25 (priming then sums 40,50,70,100).
REQ-033 in_cycles 0 -> out_cm 0; in_cycles 131071 -> out_cm 44, no overflow.
REQ-034 Three in_fail pulses -> out_err high after third; next in_cycles 58300 -> out_cm 20, out_avg_cm 20 (primed), out_err low with out_valid.
REQ-035 in_valid at 5 cycles into DIV -> ovr one pulse, single out_valid with first sample result; in_valid + in_fail same cycle -> no conversion, counter +1.
REQ-036 rst_n low for 1 cycle at DIV cycle 10 -> all outputs 0, no out_valid for 40 cycles after release.

Source files
------------

// File: rtl/range_filter.sv
// Range filter: converts ultrasonic echo width (clock cycles) into centimetres with a
// serial restoring divider, then smooths the result with a 4-sample moving average.
module range_filter #(
    parameter int CYC_PER_CM = 2915,
    parameter int FAIL_LIM   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [16:0] in_cycles,
    input  logic        in_fail,
    output logic        out_valid,
    output logic [16:0] out_cm,
    output logic [16:0] out_avg_cm,
    output logic        out_err,
    output logic        busy,
    output logic        ovr
);

    localparam int          W       = 17;
    localparam logic [W:0]  DIVISOR = (W + 1)'(CYC_PER_CM);
    localparam logic [2:0]  LIM     = 3'(FAIL_LIM);

    typedef enum logic [1:0] {IDLE, DIV, AVG} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [4:0]     step_q, step_d;
    logic [W-1:0]   win_q [4];
    logic [W-1:0]   win_d [4];
    logic [W+1:0]   sum_q, sum_d;
    logic           empty_q, empty_d;
    logic [2:0]     fail_q, fail_d;
    logic           err_q, err_d;
    logic           valid_q, valid_d;
    logic           ovr_q, ovr_d;
    logic [W-1:0]   cm_q, cm_d;
    logic [W-1:0]   avg_q, avg_d;

    // One restoring-division step: shift the next dividend bit into the remainder.
    logic [W:0]     rem_sh;
    logic [W-1:0]   rem_sub;
    logic           take;

    assign rem_sh  = {rem_q, dvd_q[W-1]};
    assign take    = rem_sh >= DIVISOR;
    assign rem_sub = rem_sh[W-1:0] - DIVISOR[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every variable gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        step_d  = step_q;
        win_d   = win_q;
        sum_d   = sum_q;
        cm_d    = cm_q;
        avg_d   = avg_q;
        valid_d = 1'b0;
        ovr_d   = (state_q != IDLE) && in_valid && !in_fail;
        fail_d  = in_fail ? ((fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1) : fail_q;
        err_d   = fail_q >= LIM;
        empty_d = empty_q | err_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !in_fail) begin
                    dvd_d   = in_cycles;
                    quo_d   = '0;
                    rem_d   = '0;
                    step_d  = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                dvd_d  = dvd_q << 1;
                rem_d  = take ? rem_sub : rem_sh[W-1:0];
                quo_d  = {quo_q[W-2:0], take};
                step_d = step_q + 5'd1;
                if (step_q == 5'd16) state_d = AVG;
            end
            AVG: begin
                cm_d = quo_q;
                if (empty_q || err_q) begin
                    // An empty window is primed so the first average equals the first sample.
                    for (int i = 0; i < 4; i++) win_d[i] = quo_q;
                    sum_d = {quo_q, 2'b00};
                end else begin
                    win_d[0] = quo_q;
                    for (int i = 1; i < 4; i++) win_d[i] = win_q[i-1];
                    sum_d = sum_q - {2'b00, win_q[3]} + {2'b00, quo_q};
                end
                avg_d   = sum_d[W+1:2];
                valid_d = 1'b1;
                fail_d  = in_fail ? 3'd1 : 3'd0;
                err_d   = 1'b0;
                empty_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the window registers are reset too; the running sum must start consistent with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            step_q  <= '0;
            for (int i = 0; i < 4; i++) win_q[i] <= '0;
            sum_q   <= '0;
            empty_q <= 1'b1;
            fail_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            cm_q    <= '0;
            avg_q   <= '0;
        end else begin
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            win_q   <= win_d;
            sum_q   <= sum_d;
            empty_q <= empty_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            cm_q    <= cm_d;
            avg_q   <= avg_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_cm     = cm_q;
    assign out_avg_cm = avg_q;
    assign out_err    = err_q;
    assign busy       = (state_q != IDLE);
    assign ovr        = ovr_q;

endmodule
